// File: rtl/num_segment_formatter.sv
// Calculator result to seven-segment frame formatter.
// Scans the BCD significand, then builds one display position per cycle.
package calc_pkg;
  localparam int NumDigits = 8;
  localparam int ExpW = 4;

  typedef struct packed {
    logic                      sign;
    logic                      error;
    logic [ExpW-1:0]           exponent;
    logic [NumDigits-1:0][3:0] digits;
  } num_t;
endpackage

module num_segment_formatter
  import calc_pkg::*;
#(
  parameter int NumDigits = calc_pkg::NumDigits
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  num_t                      num_i,
  input  logic                      valid_i,
  output logic                      ready_o,
  output logic [NumDigits-1:0][7:0] segments_o,
  output logic                      valid_o,
  input  logic                      ready_i
);

  localparam int IW = (NumDigits > 1) ? $clog2(NumDigits) : 1;
  localparam int TW = $clog2(NumDigits + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SCAN,
    S_BUILD,
    S_DONE
  } state_t;

  state_t                    r_state;
  state_t                    w_next;
  num_t                      r_num;
  logic [IW-1:0]             r_idx;
  logic [TW-1:0]             r_t;
  logic                      r_hit;
  logic                      r_bad;
  logic                      r_valid;
  logic [NumDigits-1:0][7:0] r_frame;
  logic [NumDigits-1:0][7:0] r_seg;

  logic                      w_last;
  logic [3:0]                w_dig;
  logic [7:0]                w_pos_seg;
  logic                      w_err;
  int                        w_exp;
  int                        w_cap;
  int                        w_s;
  int                        w_n;
  int                        w_p;
  int                        w_src;

  function automatic logic [7:0] enc(input logic [3:0] d);
    logic [7:0] s;
    case (d)
      4'd0:    s = 8'h7E;
      4'd1:    s = 8'h30;
      4'd2:    s = 8'h6D;
      4'd3:    s = 8'h79;
      4'd4:    s = 8'h33;
      4'd5:    s = 8'h5B;
      4'd6:    s = 8'h5F;
      4'd7:    s = 8'h70;
      4'd8:    s = 8'h7F;
      4'd9:    s = 8'h7B;
      default: s = 8'h00;
    endcase
    return s;
  endfunction

  assign w_last     = (r_idx == IW'(NumDigits - 1));
  assign w_dig      = r_num.digits[r_idx];
  assign ready_o    = (r_state == S_IDLE);
  assign valid_o    = r_valid;
  assign segments_o = r_seg;

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:  if (valid_i) w_next = S_SCAN;
      S_SCAN:  if (w_last) w_next = S_BUILD;
      S_BUILD: if (w_last) w_next = S_DONE;
      S_DONE:  if (r_valid && ready_i) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Shift s is the capped trailing-zero count; a negative full-width
  // number drops its lowest digit to make room for the minus sign.
  always_comb begin
    w_exp = int'(r_num.exponent);
    w_cap = NumDigits - 1 - w_exp;
    w_s   = (int'(r_t) < w_cap) ? int'(r_t) : w_cap;
    w_err = r_num.error || (w_exp >= NumDigits) || r_bad ||
            (r_num.sign && r_hit && (w_s == 0) &&
             (w_exp == NumDigits - 1));
    if (r_num.sign && (w_s == 0)) w_s = 1;
    w_n   = NumDigits - w_s;
    w_p   = int'(r_idx);
    w_src = w_p + w_s;
    w_pos_seg = 8'h00;
    if (w_err) begin
      if (w_p == NumDigits - 1) w_pos_seg = 8'h4F;
    end else if (!r_hit) begin
      if (w_p == 0) w_pos_seg = 8'hFE;
    end else if (w_p < w_n) begin
      w_pos_seg = enc(r_num.digits[IW'(w_src)]);
      if (w_p == w_cap - w_s) w_pos_seg[7] = 1'b1;
    end else if (r_num.sign && (w_p == w_n)) begin
      w_pos_seg = 8'h01;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state <= S_IDLE;
      r_num   <= '0;
      r_idx   <= '0;
      r_t     <= '0;
      r_hit   <= 1'b0;
      r_bad   <= 1'b0;
      r_valid <= 1'b0;
      r_frame <= '0;
      r_seg   <= '0;
    end else begin
      r_state <= w_next;
      unique case (r_state)
        S_IDLE: begin
          if (valid_i) begin
            r_num <= num_i;
            r_idx <= '0;
            r_t   <= '0;
            r_hit <= 1'b0;
            r_bad <= 1'b0;
          end
        end
        S_SCAN: begin
          if (w_dig > 4'd9) r_bad <= 1'b1;
          if (!r_hit) begin
            if (w_dig == 4'd0) r_t <= r_t + TW'(1);
            else r_hit <= 1'b1;
          end
          r_idx <= w_last ? '0 : r_idx + IW'(1);
        end
        S_BUILD: begin
          r_frame[r_idx] <= w_pos_seg;
          r_idx <= w_last ? '0 : r_idx + IW'(1);
        end
        S_DONE: begin
          if (!r_valid) begin
            r_seg   <= r_frame;
            r_valid <= 1'b1;
          end else if (ready_i) begin
            r_valid <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_num_segment_formatter.sv
// Randomized bench for num_segment_formatter against a
// behavioural frame/latency model.
module tb_num_segment_formatter;
  import calc_pkg::*;

  localparam int N = calc_pkg::NumDigits;
  localparam int LAT = 2 * N + 1;

  logic              clk = 0;
  logic              rst_i = 1;
  num_t              num_i = '0;
  logic              valid_i = 0;
  logic              ready_o;
  logic [N-1:0][7:0] segments_o;
  logic              valid_o;
  logic              ready_i = 1;

  int checks = 0;
  int errors = 0;
  bit started = 0;

  logic [7:0] SEG [10] = '{8'h7E, 8'h30, 8'h6D, 8'h79, 8'h33,
                           8'h5B, 8'h5F, 8'h70, 8'h7F, 8'h7B};

  num_segment_formatter #(.NumDigits(N)) dut (
    .clk_i(clk), .rst_i(rst_i), .num_i(num_i), .valid_i(valid_i),
    .ready_o(ready_o), .segments_o(segments_o), .valid_o(valid_o),
    .ready_i(ready_i)
  );

  always #5 clk = ~clk;

  function automatic logic [N-1:0][7:0] model(num_t n);
    logic [N-1:0][7:0] f;
    int e, t, s, cap;
    bit bad, zero;
    f = '0;
    e = int'(n.exponent);
    bad = 0;
    zero = 1;
    for (int i = 0; i < N; i++) begin
      if (n.digits[i] > 9) bad = 1;
      if (n.digits[i] != 0) zero = 0;
    end
    if (n.error || e >= N || bad) begin
      f[N-1] = 8'h4F;
      return f;
    end
    if (zero) begin
      f[0] = 8'hFE;
      return f;
    end
    t = 0;
    while (n.digits[t] == 0) t++;
    cap = N - 1 - e;
    if (t > cap) t = cap;
    s = t;
    if (n.sign && t == 0) begin
      if (e == N - 1) begin
        f[N-1] = 8'h4F;
        return f;
      end
      s = 1;
    end
    for (int i = s; i < N; i++) f[i-s] = SEG[n.digits[i]];
    f[N-1-e-s][7] = 1'b1;
    if (n.sign) f[N-s] = 8'h01;
    return f;
  endfunction

  function automatic num_t mk(bit sg, bit er, int e, logic [31:0] d);
    num_t n;
    n.sign = sg;
    n.error = er;
    n.exponent = 4'(e);
    n.digits = d;
    return n;
  endfunction

  function automatic num_t rnd();
    num_t n;
    int k;
    n.sign = 1'($urandom % 2);
    n.error = ($urandom % 16 == 0);
    if ($urandom % 8 == 0) n.exponent = 4'($urandom_range(8, 15));
    else n.exponent = 4'($urandom_range(0, 7));
    k = $urandom_range(0, N);
    for (int i = 0; i < N; i++) begin
      n.digits[i] = 4'($urandom % 10);
      if (i < k) n.digits[i] = 4'd0;
      if ($urandom % 40 == 0) n.digits[i] = 4'($urandom_range(10, 15));
    end
    if ($urandom % 10 == 0) n.digits = '0;
    return n;
  endfunction

  // Reference timing: countdown from acceptance, then hold until taken.
  logic              m_ready, m_valid;
  logic [N-1:0][7:0] m_seg, m_pend;
  int                m_cnt;

  always @(posedge clk or posedge rst_i) begin
    if (rst_i) begin
      m_ready = 1;
      m_valid = 0;
      m_seg = '0;
      m_cnt = 0;
    end else if (m_ready && valid_i) begin
      m_ready = 0;
      m_cnt = LAT;
      m_pend = model(num_i);
    end else if (m_cnt > 0) begin
      m_cnt--;
      if (m_cnt == 0) begin
        m_valid = 1;
        m_seg = m_pend;
      end
    end else if (m_valid && ready_i) begin
      m_valid = 0;
      m_ready = 1;
    end
  end

  always @(negedge clk) begin
    if (started && !rst_i) begin
      checks++;
      if (valid_o !== m_valid) begin
        errors++;
        $display("FAIL valid_o got %b want %b t=%0t",
                 valid_o, m_valid, $time);
      end
      checks++;
      if (ready_o !== m_ready) begin
        errors++;
        $display("FAIL ready_o got %b want %b t=%0t",
                 ready_o, m_ready, $time);
      end
      checks++;
      if (segments_o !== m_seg) begin
        errors++;
        $display("FAIL segments got %h want %h t=%0t",
                 segments_o, m_seg, $time);
      end
    end
  end

  task automatic chk(string nm, logic [63:0] got, logic [63:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got %h want %h", nm, got, want);
    end
  endtask

  task automatic send(num_t n, int hold);
    int k;
    k = 0;
    while (!ready_o && k < 100) begin
      @(negedge clk);
      k++;
    end
    if (!ready_o) begin
      chk("ready_wait", 64'(ready_o), 64'd1);
      return;
    end
    num_i = n;
    valid_i = 1;
    ready_i = 0;
    @(negedge clk);
    valid_i = 0;
    num_i = rnd();
    k = 0;
    while (!valid_o && k < 60) begin
      @(negedge clk);
      k++;
    end
    chk("latency", 64'(k), 64'(LAT));
    repeat (hold) begin
      valid_i = 1'($urandom % 2);
      num_i = rnd();
      @(negedge clk);
    end
    valid_i = 0;
    ready_i = 1;
    @(negedge clk);
  endtask

  num_t v_a, v_b, v_c, v_z;

  initial begin
    v_a = mk(0, 0, 0, 32'h12500000);
    v_b = mk(1, 0, 2, 32'h30000000);
    v_c = mk(1, 0, 0, 32'h12345678);
    v_z = mk(1, 0, 3, 32'h00000000);

    chk("model_a", model(v_a), 64'h0000_0000_00B0_6D5B);
    chk("model_b", model(v_b), 64'h0000_0000_0179_7EFE);
    chk("model_c", model(v_c), 64'h01B0_6D79_335B_5F70);
    chk("model_err", model(mk(0, 1, 0, 32'h12000000)),
        64'h4F00_0000_0000_0000);

    repeat (3) @(negedge clk);
    chk("rst_seg", segments_o, 64'h0);
    chk("rst_valid", 64'(valid_o), 64'd0);
    chk("rst_ready", 64'(ready_o), 64'd1);
    @(posedge clk);
    #2 rst_i = 0;
    started = 1;
    @(negedge clk);

    send(v_a, 0);
    chk("dut_a", segments_o, 64'h0000_0000_00B0_6D5B);
    send(v_b, 1);
    chk("dut_b", segments_o, 64'h0000_0000_0179_7EFE);
    send(v_c, 0);
    chk("dut_c", segments_o, 64'h01B0_6D79_335B_5F70);
    send(mk(0, 1, 0, 32'h12000000), 0);
    chk("err_flag", segments_o, 64'h4F00_0000_0000_0000);
    send(mk(0, 0, 9, 32'h12000000), 0);
    chk("err_exp", segments_o, 64'h4F00_0000_0000_0000);
    send(mk(1, 0, 7, 32'h98765432), 0);
    chk("err_sign", segments_o, 64'h4F00_0000_0000_0000);
    send(mk(0, 0, 0, 32'h1A000000), 0);
    chk("err_bcd", segments_o, 64'h4F00_0000_0000_0000);
    send(v_z, 5);
    chk("zero", segments_o, 64'h0000_0000_0000_00FE);

    for (int i = 0; i < 60; i++) send(rnd(), $urandom_range(0, 3));

    // Abort a BUILD after a frame is already on display.
    num_i = v_c;
    valid_i = 1;
    @(negedge clk);
    valid_i = 0;
    repeat (11) @(negedge clk);
    #1 rst_i = 1;
    #1;
    chk("abort_seg", segments_o, 64'h0);
    chk("abort_valid", 64'(valid_o), 64'd0);
    chk("abort_ready", 64'(ready_o), 64'd1);
    @(posedge clk);
    #2 rst_i = 0;
    @(negedge clk);
    send(v_b, 0);
    chk("after_rst", segments_o, 64'h0000_0000_0179_7EFE);

    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
